alu_arbiter: RTL

Two-port arbiter and sequencer that shares the single-cycle `alu` datapath between two requesters, e.g. the execute stage and a multi-cycle helper unit such as a branch-target or address unit. It accepts one operation at a time over a valid/ready request channel and registers the operands. It then drives the external `alu` instance for one cycle, captures Result and the three flags, and holds them on the granted port's response channel until that port accepts them. Port selection is round-robin by default.

---
 rtl/alu_arbiter_if.sv | 62 ++++++
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of the request, response and ALU-side signals of alu_arbiter.
// The slave modport is the arbiter's view; master is the requester/ALU side.
interface alu_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  // Request channels
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [2:0]            req0_op;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [2:0]            req1_op;

  // Response channels
  logic                  resp0_valid;
  logic                  resp0_ready;
  logic [DATA_WIDTH-1:0] resp0_result;
  logic                  resp0_zero;
  logic                  resp0_overflow;
  logic                  resp0_carryout;
  logic                  resp1_valid;
  logic                  resp1_ready;
  logic [DATA_WIDTH-1:0] resp1_result;
  logic                  resp1_zero;
  logic                  resp1_overflow;
  logic                  resp1_carryout;

  // Shared ALU datapath
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [2:0]            alu_op;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic                  alu_overflow;
  logic                  alu_carryout;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_result, resp0_zero, resp0_overflow, resp0_carryout,
    output resp1_valid, resp1_result, resp1_zero, resp1_overflow, resp1_carryout,
    input  resp0_ready, resp1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_zero, alu_overflow, alu_carryout
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_result, resp0_zero, resp0_overflow, resp0_carryout,
    input  resp1_valid, resp1_result, resp1_zero, resp1_overflow, resp1_carryout,
    output resp0_ready, resp1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_zero, alu_overflow, alu_carryout
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter/sequencer sharing one single-cycle ALU.
// One operation in flight: IDLE (grant) -> EXEC (drive ALU) -> RESP (hold result).
// Optional macro ALU_ARB_FIXED_PRIO_EN: port 0 always wins; otherwise round-robin.
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic          clk,
  input logic          resetn,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [2:0]            op_code_q, op_code_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  zero_q, zero_d;
  logic                  ovf_q, ovf_d;
  logic                  cout_q, cout_d;

  logic grant_valid;
  logic grant_port;
  logic req_hs;
  logic resp_hs;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: port 0 whenever it is valid
  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    grant_port  = ~bus.req0_valid;
  end
`else
  logic last_q, last_d;

  // Round-robin grant: on contention pick the port that did not win last
  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_port = ~last_q;
    end else begin
      grant_port = bus.req1_valid;
    end
  end

  // Last-winner pointer; reset to 1 so port 0 takes the first contest
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  // Pointer follows every accepted request
  always_comb begin
    last_d = last_q;
    if (req_hs) begin
      last_d = grant_port;
    end
  end
`endif

  // resetn gates ready so nothing is offered while reset is held
  assign req_hs  = (state_q == StIdle) && resetn && grant_valid;
  assign resp_hs = (state_q == StResp) && (owner_q ? bus.resp1_ready : bus.resp0_ready);

  // State, operand and response registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_code_q <= 3'b000;
      res_q     <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_code_q <= op_code_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      cout_q    <= cout_d;
    end
  end

  // Next-state: latch operands on grant, capture ALU in EXEC, wait for accept in RESP
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_code_d = op_code_q;
    res_d     = res_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    cout_d    = cout_q;
    unique case (state_q)
      StIdle: begin
        if (req_hs) begin
          state_d   = StExec;
          owner_d   = grant_port;
          op_a_d    = grant_port ? bus.req1_a  : bus.req0_a;
          op_b_d    = grant_port ? bus.req1_b  : bus.req0_b;
          op_code_d = grant_port ? bus.req1_op : bus.req0_op;
        end
      end
      StExec: begin
        state_d = StResp;
        res_d   = bus.alu_result;
        zero_d  = bus.alu_zero;
        ovf_d   = bus.alu_overflow;
        cout_d  = bus.alu_carryout;
      end
      StResp: begin
        if (resp_hs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake and datapath outputs; results are shared, valid selects the owner
  always_comb begin
    bus.req0_ready     = req_hs && !grant_port;
    bus.req1_ready     = req_hs && grant_port;
    bus.resp0_valid    = (state_q == StResp) && !owner_q;
    bus.resp1_valid    = (state_q == StResp) && owner_q;
    bus.resp0_result   = res_q;
    bus.resp0_zero     = zero_q;
    bus.resp0_overflow = ovf_q;
    bus.resp0_carryout = cout_q;
    bus.resp1_result   = res_q;
    bus.resp1_zero     = zero_q;
    bus.resp1_overflow = ovf_q;
    bus.resp1_carryout = cout_q;
    bus.alu_a          = op_a_q;
    bus.alu_b          = op_b_q;
    bus.alu_op         = op_code_q;
  end

endmodule
